// File: rtl/bcd_timer_pkg.sv
// ============================================================================
// Module      : bcd_timer_pkg
// Description : Shared types and helpers for the BCD countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd_digit(input logic [3:0] value);
        return (value <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_down.sv
// ============================================================================
// Module      : bcd_digit_down
// Description : One BCD digit of a cascadable down-counter with borrow chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] r_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= 4'd0;
        end else if (load) begin
            r_digit <= load_digit;
        end else if (dec_en && borrow_in) begin
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : (r_digit - 4'd1);
        end
    end

    assign digit      = r_digit;
    assign borrow_out = (r_digit == 4'd0) && borrow_in;

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module      : bcd_countdown_timer
// Description : Loadable BCD down-counter with start/stop and expiry pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam logic [4*DIGITS-1:0] C_ONE = (4*DIGITS)'(1);

    timer_state_t r_state;
    timer_state_t w_state_next;
    logic         r_busy;
    logic         r_done;
    logic         r_load_err;
    logic         w_done_next;
    logic         w_err_next;
    logic         w_load_ok;
    logic         w_dec;
    logic         w_valid;
    logic         w_is_one;
    logic [DIGITS:0] w_borrow;

    // Digit 0 always borrows; the end of the chain is therefore "count == 0".
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit_down u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (w_load_ok),
                .load_digit (load_val[4*i +: 4]),
                .dec_en     (w_dec),
                .borrow_in  (w_borrow[i]),
                .digit      (count[4*i +: 4]),
                .borrow_out (w_borrow[i+1])
            );
        end
    endgenerate

    always_comb begin
        w_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(load_val[4*i +: 4])) begin
                w_valid = 1'b0;
            end
        end
    end

    assign w_load_ok = load && w_valid;
    assign w_is_one  = (count == C_ONE);

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_dec        = 1'b0;
        if (load) begin
            if (w_valid) begin
                w_state_next = IDLE;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (stop) begin
            if (r_state == RUN) begin
                w_state_next = PAUSED;
            end
        end else if (start) begin
            case (r_state)
                IDLE: begin
                    if (w_borrow[DIGITS]) begin
                        w_state_next = EXPIRED;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = RUN;
                    end
                end
                PAUSED:  w_state_next = RUN;
                default: w_state_next = r_state;
            endcase
        end else if (tick && (r_state == RUN)) begin
            w_dec = 1'b1;
            if (w_is_one) begin
                w_state_next = EXPIRED;
                w_done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= (w_state_next == RUN);
            r_done     <= w_done_next;
            r_load_err <= w_err_next;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// Module      : tb_bcd_countdown_timer
// Description : Scoreboard testbench for bcd_countdown_timer (DIGITS = 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
        logic         err;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         tick;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         load_err;

    int   n_tests;
    int   n_fail;
    exp_t r_q[$];

    // Independent reference model: decimal integer count plus state code.
    int   m_cnt;
    int   m_st;   // 0 idle, 1 run, 2 paused, 3 expired

    bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic step(input logic ld, input logic [W-1:0] lv,
                        input logic sa, input logic sp, input logic tk);
        exp_t e;
        logic ok;
        int   v;
        int   mul;
        logic [3:0] nib;
        load = ld; load_val = lv; start = sa; stop = sp; tick = tk;
        e.done = 1'b0;
        e.err  = 1'b0;
        ok  = 1'b1;
        v   = 0;
        mul = 1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = lv[4*i +: 4];
            if (nib > 4'd9) ok = 1'b0;
            v   = v + int'(nib) * mul;
            mul = mul * 10;
        end
        if (ld) begin
            if (ok) begin
                m_cnt = v;
                m_st  = 0;
            end else begin
                e.err = 1'b1;
            end
        end else if (sp) begin
            if (m_st == 1) m_st = 2;
        end else if (sa) begin
            if (m_st == 0) begin
                if (m_cnt != 0) m_st = 1;
                else begin
                    m_st   = 3;
                    e.done = 1'b1;
                end
            end else if (m_st == 2) begin
                m_st = 1;
            end
        end else if (tk && m_st == 1) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_st   = 3;
                e.done = 1'b1;
            end
        end
        e.cnt  = to_bcd(m_cnt);
        e.busy = (m_st == 1);
        r_q.push_back(e);
        @(posedge clk);
        #1;
        if (r_q.size() == 0) begin
            check_val("queue_empty", 32'd1, 32'd0);
        end else begin
            e = r_q.pop_front();
            check_val("count", 32'(count), 32'(e.cnt));
            check_val("busy", 32'(busy), 32'(e.busy));
            check_val("done", 32'(done), 32'(e.done));
            check_val("load_err", 32'(load_err), 32'(e.err));
        end
        load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_cnt   = 0;
        m_st    = 0;
        reset = 1'b1; load = 1'b0; load_val = '0;
        start = 1'b0; stop = 1'b0; tick = 1'b0;
        #12;
        check_val("reset_count", 32'(count), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_err", 32'(load_err), 32'd0);
        reset = 1'b0;

        // Full countdown from 25 through the digit borrow to expiry.
        step(1'b1, 8'h25, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Cross-digit borrow, then ticks ignored while paused.
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Rejected non-BCD load, then a valid maximum load.
        step(1'b1, 8'h3A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);

        // Load beats tick in RUN; stop beats start.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h50, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Start from zero expires immediately; later requests do nothing.
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-count at 07.
        step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_count", 32'(count), 32'd0);
        check_val("async_busy", 32'(busy), 32'd0);
        check_val("async_done", 32'(done), 32'd0);
        m_cnt = 0;
        m_st  = 0;
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random mix of requests against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
